rr_arbiter83: RTL and testbench

RR_ARBITER83 -- requirements
Module: rr_arbiter83

---
 rtl/rr_arbiter83_pkg.sv | 31 +++
 rtl/rr_arbiter83_pick.sv | 66 ++++++
 rtl/rr_arbiter83.sv | 134 +++++++++++++
 tb/tb_rr_arbiter83.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_arbiter83_pkg.sv
// ---------------------------------------------------------------------------
// rr_arbiter83_pkg
// Shared definitions for the 8-requester round-robin arbiter:
//   RR_N_REQ    - number of requesters (the arbiter only supports 8)
//   RR_ID_W     - width of the binary grant index
//   RR_TIMEOUT  - default maximum hold time of one owner, in cycles (2..255)
//   RR_CNT_W    - width of the hold counter (large enough for TIMEOUT-1 = 254)
//   state_t     - arbiter FSM encoding (IDLE / OWN / GAP)
// ---------------------------------------------------------------------------
package rr_arbiter83_pkg;

    localparam int RR_N_REQ   = 8;
    localparam int RR_ID_W    = 3;
    localparam int RR_TIMEOUT = 16;
    localparam int RR_CNT_W   = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        GAP  = 2'd2
    } state_t;

    // One-hot vector with only bit 'idx' set.
    function automatic logic [RR_N_REQ-1:0] id_to_onehot(input logic [RR_ID_W-1:0] idx);
        logic [RR_N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage : rr_arbiter83_pkg

// File: rtl/rr_arbiter83_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin priority encoder. Finds the first set request
// bit searching upward from ptr+1 and wrapping from the top index to 0, so
// the requester at ptr itself is considered last.
//
// Ports:
//   req  in   N_REQ  request vector
//   ptr  in   ID_W   index of the most recent winner
//   any  out  1      at least one request is set
//   idx  out  ID_W   winning index (meaningless when any = 0)
// ---------------------------------------------------------------------------
module rr_pick
    import rr_arbiter83_pkg::*;
#(
    parameter int N_REQ = RR_N_REQ,
    parameter int ID_W  = RR_ID_W
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic             any,
    output logic [ID_W-1:0]  idx
);

    // ext[j] = req[(j+1) mod N_REQ]. Indexing it at ptr+k gives the request
    // k positions after the pointer, so no modulo arithmetic is needed and
    // every bit of the extended vector is reachable.
    logic [2*N_REQ-2:0] ext;
    logic [N_REQ-1:0]   rot;
    logic [N_REQ-1:0]   hit;
    logic [ID_W-1:0]    off;

    assign ext = {req, req[N_REQ-1:1]};

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_rot
            // rot[gi] is the request gi+1 places after the pointer.
            assign rot[gi] = ext[32'(ptr) + gi];
        end

        for (gi = 0; gi < N_REQ; gi++) begin : g_hit
            // Lowest set bit of the rotated vector wins.
            if (gi == 0) begin : g_first
                assign hit[gi] = rot[gi];
            end else begin : g_rest
                assign hit[gi] = rot[gi] & ~(|rot[gi-1:0]);
            end
        end
    endgenerate

    // hit is one-hot (or zero), so a plain scan encodes it.
    always_comb begin
        off = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (hit[k]) begin
                off = ID_W'(k);
            end
        end
    end

    // N_REQ is a power of two, so ID_W-bit addition wraps 7 -> 0 naturally.
    assign idx = ptr + ID_W'(1) + off;
    assign any = |req;

endmodule : rr_pick

// File: rtl/rr_arbiter83.sv
// ---------------------------------------------------------------------------
// rr_arbiter83
// Round-robin arbiter for 8 requesters with a per-owner hold limit.
// IDLE picks a winner (round-robin from the last winner), OWN holds the
// grant until release, requester drop or hold-limit expiry, and GAP inserts
// one dead cycle before arbitration resumes. All outputs are registered.
//
// Ports:
//   clk            in   1      rising-edge clock
//   rst            in   1      asynchronous active-high reset
//   req            in   N_REQ  level-sensitive request vector
//   release_grant  in   1      owner finished (only looked at in OWN); the
//                              natural name 'release' is an SV keyword
//   gnt            out  N_REQ  one-hot grant, zero when nobody owns
//   gnt_id         out  ID_W   binary index of gnt, zero when gnt is zero
//   busy           out  1      high while gnt is non-zero
//   timeout        out  1      one-cycle pulse when the hold limit revokes
// ---------------------------------------------------------------------------
module rr_arbiter83
    import rr_arbiter83_pkg::*;
#(
    parameter int N_REQ   = RR_N_REQ,
    parameter int ID_W    = RR_ID_W,
    parameter int TIMEOUT = RR_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             release_grant,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             busy,
    output logic             timeout
);

    localparam logic [RR_CNT_W-1:0] HOLD_LAST = RR_CNT_W'(TIMEOUT - 1);

    state_t                state_reg,   state_next;
    logic [ID_W-1:0]       ptr_reg,     ptr_next;
    logic [RR_CNT_W-1:0]   cnt_reg,     cnt_next;
    logic [N_REQ-1:0]      gnt_reg,     gnt_next;
    logic [ID_W-1:0]       gnt_id_reg,  gnt_id_next;
    logic                  busy_reg,    busy_next;
    logic                  timeout_reg, timeout_next;

    logic                  pick_any;
    logic [ID_W-1:0]       pick_idx;

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .req (req),
        .ptr (ptr_reg),
        .any (pick_any),
        .idx (pick_idx)
    );

    // ptr resets to the top index so requester 0 has first priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            ptr_reg     <= ID_W'(N_REQ - 1);
            cnt_reg     <= '0;
            gnt_reg     <= '0;
            gnt_id_reg  <= '0;
            busy_reg    <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            ptr_reg     <= ptr_next;
            cnt_reg     <= cnt_next;
            gnt_reg     <= gnt_next;
            gnt_id_reg  <= gnt_id_next;
            busy_reg    <= busy_next;
            timeout_reg <= timeout_next;
        end
    end

    // Outputs are computed for the state being entered, so each register
    // already holds the value that belongs to the current state.
    always_comb begin
        state_next   = state_reg;
        ptr_next     = ptr_reg;
        cnt_next     = '0;
        gnt_next     = '0;
        gnt_id_next  = '0;
        busy_next    = 1'b0;
        timeout_next = 1'b0;

        case (state_reg)
            IDLE: begin
                if (pick_any) begin
                    state_next  = OWN;
                    ptr_next    = pick_idx;
                    gnt_next    = id_to_onehot(pick_idx);
                    gnt_id_next = pick_idx;
                    busy_next   = 1'b1;
                end
            end

            OWN: begin
                // Release (or the owner dropping its request) has priority
                // over the hold limit, so timeout never fires alongside it.
                if (release_grant || !req[gnt_id_reg]) begin
                    state_next = GAP;
                end else if (cnt_reg == HOLD_LAST) begin
                    state_next   = GAP;
                    timeout_next = 1'b1;
                end else begin
                    cnt_next    = cnt_reg + RR_CNT_W'(1);
                    gnt_next    = gnt_reg;
                    gnt_id_next = gnt_id_reg;
                    busy_next   = 1'b1;
                end
            end

            GAP: begin
                // Requests are deliberately not looked at here.
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign gnt     = gnt_reg;
    assign gnt_id  = gnt_id_reg;
    assign busy    = busy_reg;
    assign timeout = timeout_reg;

endmodule : rr_arbiter83

// File: tb/tb_rr_arbiter83.sv
// ---------------------------------------------------------------------------
// tb_rr_arbiter83
// Directed stimulus pushes the expected grant sequence (owner, hold length,
// timeout flag, idle cycles before the grant) into a queue; a monitor
// observes each completed grant and compares it against the queue head.
// ---------------------------------------------------------------------------
module tb_rr_arbiter83;

    logic       clk           = 1'b0;
    logic       rst           = 1'b1;
    logic [7:0] req           = 8'hFF;
    logic       release_grant = 1'b0;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       busy;
    logic       timeout;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int id;
        int len;
        int tmo;
        int gap;   // -1 = not checked
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    rr_arbiter83 #(
        .N_REQ   (8),
        .ID_W    (3),
        .TIMEOUT (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .release_grant (release_grant),
        .gnt           (gnt),
        .gnt_id        (gnt_id),
        .busy          (busy),
        .timeout       (timeout)
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, want, want);
        end
    endfunction

    function automatic int enc(input logic [7:0] v);
        int r = 0;
        for (int k = 0; k < 8; k++) begin
            if (v[k] === 1'b1) r = k;
        end
        return r;
    endfunction

    function automatic void push(input int id, input int len, input int tmo, input int gap);
        exp_t e;
        e.id  = id;
        e.len = len;
        e.tmo = tmo;
        e.gap = gap;
        exp_q.push_back(e);
    endfunction

    // Wait (at negedges) until busy equals level; bounded.
    task automatic wait_level(input logic level, output bit ok);
        int n = 0;
        ok = 1'b1;
        while (busy !== level) begin
            @(negedge clk);
            n++;
            if (n > 40) begin
                ok = 1'b0;
                break;
            end
        end
    endtask

    // Serve the next grant: end it after 'hold' cycles by release (or by
    // dropping req when drop=1); hold=0 lets the hold limit expire.
    task automatic serve(input int hold, input bit drop);
        bit ok;
        @(negedge clk);
        wait_level(1'b1, ok);
        if (!ok) begin
            chk("grant_wait", 0, 1);
            return;
        end
        if (hold > 0) begin
            repeat (hold - 1) @(negedge clk);
            if (drop) req = 8'h00;
            else      release_grant = 1'b1;
            @(negedge clk);
            release_grant = 1'b0;
        end
        wait_level(1'b0, ok);
        if (!ok) chk("end_wait", 0, 1);
    endtask

    // Monitor: per-cycle invariants plus one scoreboard compare per grant.
    initial begin
        bit         in_grant = 1'b0;
        bit         stable   = 1'b1;
        bit         prev_tmo = 1'b0;
        int         len      = 0;
        int         zeros    = 0;
        int         cap_gap  = 0;
        logic [7:0] cap_gnt  = '0;
        logic [2:0] cap_id   = '0;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_grant = 1'b0;
                zeros    = 0;
                prev_tmo = 1'b0;
            end else begin
                chk("onehot0", 32'($onehot0(gnt)), 1);
                chk("id_encode", gnt_id, enc(gnt));
                chk("busy_vs_gnt", busy, (gnt != 8'h00) ? 1 : 0);
                if (timeout) chk("tmo_single_pulse_no_gnt", {prev_tmo, busy}, 0);
                prev_tmo = timeout;
                if (busy) begin
                    if (!in_grant) begin
                        in_grant = 1'b1;
                        len      = 1;
                        stable   = 1'b1;
                        cap_gnt  = gnt;
                        cap_id   = gnt_id;
                        cap_gap  = zeros;
                    end else begin
                        len++;
                        if (gnt !== cap_gnt || gnt_id !== cap_id) stable = 1'b0;
                    end
                    zeros = 0;
                end else begin
                    if (in_grant) begin
                        in_grant = 1'b0;
                        if (exp_q.size() == 0) begin
                            chk("unexpected_grant", 1, 0);
                        end else begin
                            e = exp_q.pop_front();
                            $display("txn grant id=%0d gnt=0x%02h len=%0d timeout=%0d gap=%0d (want id=%0d len=%0d timeout=%0d)",
                                     cap_id, cap_gnt, len, timeout, cap_gap, e.id, e.len, e.tmo);
                            chk("grant_gnt", cap_gnt, 32'(1) << e.id);
                            chk("grant_id", cap_id, e.id);
                            chk("hold_len", len, e.len);
                            chk("timeout_flag", timeout, e.tmo);
                            chk("hold_stable", stable, 1);
                            if (e.gap >= 0) chk("gap_cycles", cap_gap, e.gap);
                        end
                    end
                    zeros++;
                end
            end
        end
    end

    // Directed stimulus.
    initial begin
        bit ok;

        // Reset state while all requesters are asking.
        repeat (3) @(negedge clk);
        chk("rst_gnt", gnt, 0);
        chk("rst_gnt_id", gnt_id, 0);
        chk("rst_busy", busy, 0);
        chk("rst_timeout", timeout, 0);

        // Full rotation 0..7,0 after reset (ptr starts at 7).
        push(0, 1, 0, -1);
        for (int i = 1; i < 8; i++) push(i, 1, 0, 2);
        push(0, 1, 0, 2);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("first_gnt", gnt, 8'h01);
        chk("first_gnt_id", gnt_id, 0);
        chk("first_busy", busy, 1);
        for (int i = 0; i < 9; i++) serve(1, 1'b0);

        // ptr=0: lone req 4, then 0x90 with ptr=4 -> 7, then 4.
        req = 8'h10;
        push(4, 1, 0, 2);
        serve(1, 1'b0);
        req = 8'h90;
        push(7, 2, 0, 2);
        push(4, 3, 0, 2);
        serve(2, 1'b0);
        serve(3, 1'b0);

        // Hold limit expiry on requester 2, then re-grant.
        req = 8'h04;
        push(2, 16, 1, 2);
        push(2, 1, 0, 2);
        serve(0, 1'b0);
        serve(1, 1'b0);

        // Release on the last allowed cycle beats the limit; one cycle earlier.
        push(2, 16, 0, 2);
        serve(16, 1'b0);
        push(2, 15, 0, 2);
        serve(15, 1'b0);

        // Owner drops its request.
        push(2, 3, 0, 2);
        serve(3, 1'b1);

        // Asynchronous reset mid-grant; ptr must restart from 7.
        repeat (2) @(negedge clk);
        req = 8'h20;
        @(negedge clk);
        wait_level(1'b1, ok);
        if (!ok) chk("pre_rst_wait", 0, 1);
        chk("pre_rst_gnt", gnt, 8'h20);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_gnt", gnt, 0);
        chk("arst_gnt_id", gnt_id, 0);
        chk("arst_busy", busy, 0);
        chk("arst_timeout", timeout, 0);
        @(negedge clk);
        req = 8'h60;
        push(5, 1, 0, -1);
        push(6, 1, 0, 2);
        @(negedge clk);
        rst = 1'b0;
        serve(1, 1'b0);
        serve(1, 1'b0);

        repeat (4) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_rr_arbiter83
